// File: rtl/nco_defs.sv
// rtl/nco_defs.sv - shared defaults, quadrant codes and sine table helpers for nco_qw
package nco_defs;

    localparam int NCO_ACC_W  = 16;
    localparam int NCO_ADDR_W = 4;
    localparam int NCO_OUT_W  = 8;

    localparam real NCO_PI = 3.14159265358979323846;

    // Quadrant is the top two phase bits; odd quadrants read the table mirrored,
    // the upper half of the circle is negated.
    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_e;

    // Peak magnitude of a signed out_w-bit sample, symmetric about zero.
    function automatic int nco_amp(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

    // Round half away from zero.
    function automatic int nco_round(input real x);
        if (x >= 0.0) begin
            return $rtoi(x + 0.5);
        end
        return -$rtoi(0.5 - x);
    endfunction

    // Quarter-wave entry k, sampled at the middle of its step so the mirrored
    // read in odd quadrants lands on exactly the same angles.
    function automatic int nco_rom_entry(input int k, input int addr_w, input int amp);
        real ang;
        ang = (NCO_PI / 2.0) * (real'(k) + 0.5) / real'(1 << addr_w);
        return nco_round(real'(amp) * $sin(ang));
    endfunction

endpackage

// File: rtl/nco_qw_rom.sv
// rtl/nco_qw_rom.sv - quarter-wave sine table with quadrant mirroring, registered read
module nco_qw_rom
    import nco_defs::*;
#(
    parameter int ADDR_W = NCO_ADDR_W,
    parameter int OUT_W  = NCO_OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              valid_i,
    input  logic [1:0]        quad_i,
    input  logic [ADDR_W-1:0] idx_i,
    output logic [OUT_W-2:0]  mag_o,
    output logic              neg_o,
    output logic              valid_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int MAG_W = OUT_W - 1;
    localparam int AMP   = nco_amp(OUT_W);

    logic [MAG_W-1:0]  table_w [DEPTH];
    logic [ADDR_W-1:0] addr;
    logic              mirror;

    logic [MAG_W-1:0]  mag_q, mag_d;
    logic              neg_q, neg_d;
    logic              valid_q, valid_d;

    // Table contents fixed at elaboration from the sine formula.
    for (genvar k = 0; k < DEPTH; k++) begin : g_table
        assign table_w[k] = MAG_W'(nco_rom_entry(k, ADDR_W, AMP));
    end

    assign mirror = (quad_i == Q1) || (quad_i == Q3);
    assign addr   = mirror ? ~idx_i : idx_i;

    // Next-state for the stage-2 magnitude, sign and valid; a clear drops the slot.
    always_comb begin
        mag_d   = table_w[addr];
        neg_d   = quad_i[1];
        valid_d = valid_i && !clr_i;
    end

    // Stage-2 registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q   <= '0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            valid_q <= valid_d;
        end
    end

    assign mag_o   = mag_q;
    assign neg_o   = neg_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/nco_qw.sv
// rtl/nco_qw.sv - NCO top: phase accumulator, FCW shadow/apply, phase slice and sign stage
module nco_qw
    import nco_defs::*;
#(
    parameter int ACC_W  = NCO_ACC_W,
    parameter int ADDR_W = NCO_ADDR_W,
    parameter int OUT_W  = NCO_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic [ACC_W-1:0]        fcw_in,
    input  logic                    fcw_wr,
    input  logic                    sync_update,
    input  logic [ACC_W-1:0]        poff,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid,
    output logic                    fcw_pending
);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  fcw_active_q, fcw_active_d;
    logic [ACC_W-1:0]  fcw_shadow_q, fcw_shadow_d;
    logic              pending_q, pending_d;

    logic [ACC_W:0]    acc_sum;
    logic              step;
    logic              wrap;
    logic              fcw_apply;

    logic [ACC_W-1:0]  ph;
    logic [1:0]        quad1_q, quad1_d;
    logic [ADDR_W-1:0] idx1_q, idx1_d;
    logic              v1_q, v1_d;

    logic [OUT_W-2:0]  mag2;
    logic              neg2;
    logic              v2;

    logic [OUT_W-1:0]  mag_ext;
    logic signed [OUT_W-1:0] dout_q, dout_d;
    logic              v3_q, v3_d;

    // The carry out of the phase add marks the accumulator wrap.
    assign acc_sum = {1'b0, acc_q} + {1'b0, fcw_active_q};
    assign step    = en && !clr;
    assign wrap    = step && acc_sum[ACC_W];

    // In sync mode a word written in the wrap cycle itself waits for the next wrap.
    assign fcw_apply = pending_q && (sync_update ? (wrap && !fcw_wr) : 1'b1);

    // Accumulator and FCW shadow/active next-state; the wrap-cycle add uses the old word.
    always_comb begin
        acc_d        = acc_q;
        fcw_active_d = fcw_active_q;
        fcw_shadow_d = fcw_shadow_q;
        pending_d    = pending_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_sum[ACC_W-1:0];
        end
        if (fcw_apply) begin
            fcw_active_d = fcw_shadow_q;
            pending_d    = 1'b0;
        end
        if (fcw_wr) begin
            fcw_shadow_d = fcw_in;
            pending_d    = 1'b1;
        end
    end

    // Accumulator and FCW registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            fcw_active_q <= '0;
            fcw_shadow_q <= '0;
            pending_q    <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            fcw_active_q <= fcw_active_d;
            fcw_shadow_q <= fcw_shadow_d;
            pending_q    <= pending_d;
        end
    end

    // Stage 1 samples the pre-update accumulator plus offset, truncated to table resolution.
    assign ph = acc_q + poff;

    if (ACC_W > ADDR_W + 2) begin : g_trunc
        logic unused_ph_lsbs;
        assign unused_ph_lsbs = ^ph[ACC_W-ADDR_W-3:0];
    end

    // Stage-1 next-state: quadrant, table index and launch flag.
    always_comb begin
        quad1_d = ph[ACC_W-1 -: 2];
        idx1_d  = ph[ACC_W-3 -: ADDR_W];
        v1_d    = step;
    end

    // Stage-1 registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quad1_q <= '0;
            idx1_q  <= '0;
            v1_q    <= 1'b0;
        end else begin
            quad1_q <= quad1_d;
            idx1_q  <= idx1_d;
            v1_q    <= v1_d;
        end
    end

    nco_qw_rom #(
        .ADDR_W (ADDR_W),
        .OUT_W  (OUT_W)
    ) u_rom (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .valid_i (v1_q),
        .quad_i  (quad1_q),
        .idx_i   (idx1_q),
        .mag_o   (mag2),
        .neg_o   (neg2),
        .valid_o (v2)
    );

    // Stage-3 next-state: apply the sign; dout holds whenever no sample arrives.
    always_comb begin
        mag_ext = {1'b0, mag2};
        dout_d  = dout_q;
        v3_d    = v2 && !clr;
        if (v2 && !clr) begin
            dout_d = neg2 ? $signed({OUT_W{1'b0}} - mag_ext) : $signed(mag_ext);
        end
    end

    // Stage-3 output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
            v3_q   <= 1'b0;
        end else begin
            dout_q <= dout_d;
            v3_q   <= v3_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = v3_q;
    assign fcw_pending = pending_q;

endmodule

// File: tb/tb_nco_qw.sv
// tb/tb_nco_qw.sv - self-checking bench for nco_qw with a sine model and directed vectors
module tb_nco_qw;

    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Instance A: default parameters.
    logic              a_en = 1'b0, a_clr = 1'b0, a_fcw_wr = 1'b0, a_sync = 1'b0;
    logic [15:0]       a_fcw_in = '0, a_poff = '0;
    logic signed [7:0] a_dout;
    logic              a_valid, a_pend;

    // Instance B: finer table, wider output.
    logic               b_en = 1'b0, b_clr = 1'b0, b_fcw_wr = 1'b0, b_sync = 1'b0;
    logic [15:0]        b_fcw_in = '0, b_poff = '0;
    logic signed [11:0] b_dout;
    logic               b_valid, b_pend;

    int n_assert = 0;
    int n_fail   = 0;
    int asamp[$];
    int bsamp[$];

    always #5 clk = ~clk;

    nco_qw u_a (
        .clk(clk), .rst(rst), .en(a_en), .clr(a_clr), .fcw_in(a_fcw_in), .fcw_wr(a_fcw_wr),
        .sync_update(a_sync), .poff(a_poff), .dout(a_dout), .dout_valid(a_valid),
        .fcw_pending(a_pend)
    );

    nco_qw #(.ACC_W(16), .ADDR_W(5), .OUT_W(12)) u_b (
        .clk(clk), .rst(rst), .en(b_en), .clr(b_clr), .fcw_in(b_fcw_in), .fcw_wr(b_fcw_wr),
        .sync_update(b_sync), .poff(b_poff), .dout(b_dout), .dout_valid(b_valid),
        .fcw_pending(b_pend)
    );

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Ideal sine of the phase slot containing ph, taken at the slot centre.
    function automatic int ref_sample(input int ph, input int acc_w, input int addr_w, input int out_w);
        int  slot;
        real amp, ang, x;
        slot = ph >> (acc_w - addr_w - 2);
        amp  = real'((1 << (out_w - 1)) - 1);
        ang  = 2.0 * PI * (real'(slot) + 0.5) / (4.0 * real'(1 << addr_w));
        x    = amp * $sin(ang);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    // Behavioural model of instance A: phase as an integer mod 2^16, samples in a latency line.
    int m_acc, m_fcw, m_shadow, m_dout;
    bit m_pend;
    bit mv[3];
    int mval[3];

    always @(posedge clk or posedge rst) begin
        int  sum;
        bit  wrap, apply;
        if (rst) begin
            m_acc <= 0; m_fcw <= 0; m_shadow <= 0; m_pend <= 0; m_dout <= 0;
            for (int i = 0; i < 3; i++) begin mv[i] <= 0; mval[i] <= 0; end
        end else begin
            if (a_clr) begin
                for (int i = 0; i < 3; i++) mv[i] <= 0;
            end else begin
                if (mv[1]) m_dout <= mval[1];
                mv[2] <= mv[1]; mval[2] <= mval[1];
                mv[1] <= mv[0]; mval[1] <= mval[0];
                mv[0] <= a_en;
                if (a_en) mval[0] <= ref_sample((m_acc + int'(a_poff)) % 65536, 16, 4, 8);
            end
            sum   = m_acc + m_fcw;
            wrap  = a_en && !a_clr && (sum >= 65536);
            apply = m_pend && (a_sync ? (wrap && !a_fcw_wr) : 1'b1);
            if (a_clr) m_acc <= 0;
            else if (a_en) m_acc <= sum % 65536;
            if (apply) m_fcw <= m_shadow;
            if (a_fcw_wr) begin
                m_shadow <= int'(a_fcw_in);
                m_pend   <= 1'b1;
            end else if (apply) begin
                m_pend <= 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison of instance A against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_valid", int'(a_valid), int'(mv[2]));
            check("cyc_dout", int'(a_dout), m_dout);
            check("cyc_pending", int'(a_pend), int'(m_pend));
        end
    end

    // Sample collectors.
    always @(negedge clk) begin
        if (!rst && a_valid) asamp.push_back(int'(a_dout));
        if (!rst && b_valid) bsamp.push_back(int'(b_dout));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write_a(input int v);
        a_fcw_in = 16'(v);
        a_fcw_wr = 1'b1;
        tick();
        a_fcw_wr = 1'b0;
    endtask

    task automatic wait_a(input int n, input int budget, input string name);
        int c = 0;
        while (asamp.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        #2;
        check(name, (asamp.size() >= n) ? 1 : 0, 1);
    endtask

    initial begin
        int c, sum, prev;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_dout", int'(a_dout), 0);
        check("reset_valid", int'(a_valid), 0);
        check("reset_pending", int'(a_pend), 0);

        // Basic tone, immediate FCW load.
        write_a(1024);
        check("imm_pending_set", int'(a_pend), 1);
        tick();
        check("imm_pending_clr", int'(a_pend), 0);
        asamp.delete();
        a_en = 1'b1;
        tick(); tick();
        check("lat_cycle2_valid", int'(a_valid), 0);
        tick();
        check("lat_cycle3_valid", int'(a_valid), 1);
        wait_a(65, 200, "tone_timeout");
        check("tone_s0", asamp[0], 6);
        check("tone_s1", asamp[1], 19);
        check("tone_s15", asamp[15], 127);
        check("tone_s16", asamp[16], 127);
        check("tone_s32", asamp[32], -6);
        check("tone_s48", asamp[48], -127);
        check("tone_period", asamp[64], asamp[0]);

        // Phase offset of a quarter turn.
        a_en = 1'b0; a_clr = 1'b1; tick(); a_clr = 1'b0;
        a_poff = 16'd16384;
        asamp.delete();
        a_en = 1'b1;
        wait_a(1, 20, "poff_timeout");
        check("poff_s0", asamp[0], 127);
        a_en = 1'b0; a_clr = 1'b1; tick(); a_clr = 1'b0;
        a_poff = '0;

        // Sync update: new word takes effect only at the wrap.
        a_sync = 1'b1;
        asamp.delete();
        a_en = 1'b1;
        repeat (10) tick();
        write_a(2048);
        check("sync_pending_held", int'(a_pend), 1);
        wait_a(100, 300, "sync_timeout");
        check("sync_pending_done", int'(a_pend), 0);
        check("sync_s63", asamp[63], -6);
        check("sync_s64", asamp[64], 6);
        check("sync_s65", asamp[65], 31);
        check("sync_period32", asamp[96], asamp[64]);
        a_en = 1'b0; a_clr = 1'b1; tick(); a_clr = 1'b0;
        a_sync = 1'b0;

        // en gaps freeze the accumulator.
        write_a(1024);
        tick();
        asamp.delete();
        a_en = 1'b1; tick();
        a_en = 1'b0; tick();
        a_en = 1'b1; tick();
        a_en = 1'b0;
        repeat (5) tick();
        check("gap_count", asamp.size(), 2);
        check("gap_s0", asamp[0], 6);
        check("gap_s1", asamp[1], 19);

        // clr with en high drops in-flight samples and restarts phase.
        a_en = 1'b1;
        repeat (5) tick();
        a_clr = 1'b1; tick(); a_clr = 1'b0;
        check("clr_valid_drop", int'(a_valid), 0);
        asamp.delete();
        c = 0;
        while (!a_valid && c < 10) begin tick(); c++; end
        check("clr_gap_cycles", c, 3);
        wait_a(1, 10, "clr_timeout");
        check("clr_first", asamp[0], 6);

        // Asynchronous reset in the middle of a run.
        a_sync = 1'b1;
        write_a(3000);
        prev = int'(a_dout);
        check("rst_pre_pending", int'(a_pend), 1);
        check("rst_pre_nonzero", (prev != 0) ? 1 : 0, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_async_dout", int'(a_dout), 0);
        check("rst_async_valid", int'(a_valid), 0);
        check("rst_async_pending", int'(a_pend), 0);
        a_en = 1'b0; a_sync = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Full table sweep on the wide instance.
        b_fcw_in = 16'd512; b_fcw_wr = 1'b1; tick(); b_fcw_wr = 1'b0;
        tick();
        bsamp.delete();
        b_en = 1'b1;
        c = 0;
        while (bsamp.size() < 128 && c < 400) begin @(posedge clk); c++; end
        #2;
        b_en = 1'b0;
        check("sweep_timeout", (bsamp.size() >= 128) ? 1 : 0, 1);
        if (bsamp.size() >= 128) begin
            check("sweep_s0", bsamp[0], 50);
            check("sweep_s31", bsamp[31], 2046);
            sum = 0;
            for (int k = 0; k < 128; k++) begin
                check($sformatf("sweep_k%0d", k), bsamp[k], ref_sample(k * 512, 16, 5, 12));
                sum += bsamp[k];
            end
            check("sweep_sum", sum, 0);
            for (int k = 0; k < 64; k++) check($sformatf("sweep_odd_k%0d", k), bsamp[k] + bsamp[k + 64], 0);
            for (int k = 0; k < 32; k++) check($sformatf("sweep_mirror_k%0d", k), bsamp[k], bsamp[63 - k]);
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_qw.md
Name: nco_qw

Overview:
- Parametrised numerically controlled oscillator: phase accumulator, quarter-wave sine ROM with quadrant mirroring, signed registered output.
- Successor to the 16-entry full-period sine lookup: table depth, output width and accumulator width are parameters, and a frequency control word is added.
- Also adds a phase offset, phase-continuous frequency updates and a valid-tagged 3-stage pipeline.
- Feeds the DAC/modulator path; one instance per carrier.

Parameters:
ACC_W, 16, phase accumulator width (ACC_W >= ADDR_W+2)
ADDR_W, 4, log2 of quarter-wave table depth (2^ADDR_W entries per quadrant)
OUT_W, 8, signed output sample width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  advance accumulator and launch one sample this cycle
clr  in  1  synchronous phase clear
fcw_in  in  ACC_W  frequency control word to load
fcw_wr  in  1  write strobe for fcw_in
sync_update  in  1  1: apply new FCW at next accumulator wrap; 0: apply next cycle
poff  in  ACC_W  phase offset added after accumulator, sampled with en
dout  out  OUT_W  signed sine sample
dout_valid  out  1  dout holds a new sample this cycle
fcw_pending  out  1  written FCW not yet applied

Behaviour:
- Reset (async, any time, incl. mid-sample): acc=0, fcw_active=0, fcw_shadow=0, fcw_pending=0, all pipeline valids=0, dout=0, dout_valid=0.
- Accumulator: when en=1, acc <= acc + fcw_active, modulo 2^ACC_W. Carry-out of that add = wrap. acc holds when en=0.
- Stage 1 (edge ending cycle n, en=1): ph = acc(n) + poff, mod 2^ACC_W (pre-update acc). q = ph[ACC_W-1:ACC_W-2]; i = ph[ACC_W-3:ACC_W-2-ADDR_W]; lower bits truncated, no dither.
- Stage 2: ROM index = i when q is 0 or 2, ~i when q is 1 or 3. Magnitude m registered. neg = q[1] is delayed alongside.
- ROM entry k = round((2^(OUT_W-1)-1) * sin(pi/2 * (k+0.5)/2^ADDR_W)). Entries are unsigned, OUT_W-1 bits. The half-step offset makes mirroring exact; no zero crossings appear in the table.
- Stage 3: dout = neg ? -m : +m, two's complement. Never overflows, since |m| <= 2^(OUT_W-1)-1.
- Latency: sample launched by en in cycle n appears on dout with dout_valid=1 in cycle n+3. dout_valid is en delayed 3 cycles. dout holds its last value while dout_valid=0.
- FCW write: fcw_wr=1 captures fcw_in into fcw_shadow and sets fcw_pending. A later write before application overwrites shadow (last write wins).
- Apply, sync_update=0: fcw_active <= fcw_shadow on the cycle after the write; pending clears.
- Apply, sync_update=1: transfer happens on the edge where en=1 and wrap=1 and pending was already set before that cycle. The add in the wrap cycle still uses the old FCW.
- Write and wrap in the same cycle (sync mode): the write sets pending only, and the transfer waits for the next wrap.
- clr=1: acc <= 0 and stage 1–3 valids cleared. In-flight samples are dropped; dout is unchanged. FCW registers and pending are unaffected.
- clr has priority over en in the same cycle.
- fcw_active=0 with en=1: constant phase. Output is a repeated sample at phase poff.

Decomposition:
- Shared header/package nco_defs: default ACC_W/ADDR_W/OUT_W, quadrant encodings (Q0..Q3), the ROM amplitude constant, and the rounding function used to build the table.
- One sub-module: nco_qw_rom. Registered read, depth 2^ADDR_W, width OUT_W-1, contents generated at elaboration from the table formula. It implements stage 2.
- Top level holds the accumulator, FCW shadow/active control, stage 1, and the sign stage.

Test Plan:
- Reset/idle (default parameters): assert rst mid-run -> dout=0, dout_valid=0, fcw_pending=0 immediately, with no clock edge needed.
- Basic tone: fcw=1024 (immediate), poff=0, en held high -> first valid sample 3 cycles after en. Samples 0,1,15,16,32,48 = +6, +19, +127, +127, -6, -127. Period 64 samples.
- Phase offset: fcw=1024, poff=16384 -> sample 0 = +127 (quadrant 1, index 15).
- Sync update: fcw=1024, sync_update=1, write fcw=2048 at sample 10 -> fcw_pending=1 until the wrap at sample 63. Samples 0..63 keep step 1024; the following samples step 2048 (period 32); no phase jump.
- en gaps/clr: toggle en 1,0,1 -> dout_valid pattern 1,0,1 delayed 3 cycles, accumulator frozen in the gap. Assert clr with en=1 -> 3 in-flight samples dropped; next sample = +6.
- Table sweep, ADDR_W=5, OUT_W=12: step fcw through all 128 indices -> every dout matches the formula, output is symmetric, and the sum over one period = 0.
